// File: rtl/sc_fetch_unit_pkg.sv
// rtl/sc_fetch_unit_pkg.sv - shared encodings for the fetch stage and control unit
// Contents: next-PC select codes, fetch state enum, fault codes, default reset PC.
package sc_fetch_unit_pkg;

    // Next-PC select; the control unit drives the same encoding.
    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JR  = 2'b10;
    localparam logic [1:0] PC_J   = 2'b11;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_VALID = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/sc_npc_mux.sv
// rtl/sc_npc_mux.sv - combinational next-PC select with word-alignment check
// Ports: pcsource selects among pc4/bpc/rpc/jpc; npc is the chosen target,
//        misaligned flags a target whose low two bits are nonzero.
module sc_npc_mux
    import sc_fetch_unit_pkg::*;
(
    input  logic [1:0]  pcsource,
    input  logic [31:0] pc4,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic [31:0] npc,
    output logic        misaligned
);

    always_comb begin
        npc = pc4;
        case (pcsource)
            PC_SEQ:  npc = pc4;
            PC_BR:   npc = bpc;
            PC_JR:   npc = rpc;
            PC_J:    npc = jpc;
            default: npc = pc4;
        endcase
    end

    assign misaligned = |npc[1:0];

endmodule

// File: rtl/sc_fetch_unit.sv
// rtl/sc_fetch_unit.sv - instruction fetch stage with req/ack memory port and sticky fault
// Ports: clock/reset (sync, active-high); pcsource/bpc/rpc/jpc/advance from
//        decode/datapath; imem_req/imem_addr/imem_ack/imem_rdata to instruction
//        memory; inst/pc/pc4/inst_valid to decode; fault/fault_code status.
module sc_fetch_unit
    import sc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    input  logic        advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        inst_valid,
    output logic        fault,
    output logic [1:0]  fault_code
);

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    fetch_state_t state;
    fetch_state_t state_nx;
    logic [7:0]   wait_cnt;
    logic         timeout_hit;
    logic [31:0]  npc;
    logic         misaligned;

    assign pc4         = pc + 32'd4;
    assign imem_addr   = pc;
    // wait_cnt numbers the unanswered request cycles from zero, so the limit
    // is reached on the TIMEOUT-th request cycle.
    assign timeout_hit = (wait_cnt == WAIT_LIMIT);

    sc_npc_mux u_npc_mux (
        .pcsource   (pcsource),
        .pc4        (pc4),
        .bpc        (bpc),
        .rpc        (rpc),
        .jpc        (jpc),
        .npc        (npc),
        .misaligned (misaligned)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            inst       <= '0;
            wait_cnt   <= '0;
            fault_code <= FC_NONE;
        end else begin
            state <= state_nx;
            case (state)
                ST_FETCH: begin
                    // ack wins over a simultaneous timeout
                    if (imem_ack) begin
                        inst     <= imem_rdata;
                        wait_cnt <= '0;
                    end else if (timeout_hit) begin
                        fault_code <= FC_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_VALID: begin
                    if (advance) begin
                        if (misaligned) fault_code <= FC_MISALIGN;
                        else            pc         <= npc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_FETCH: begin
                if (imem_ack)         state_nx = ST_VALID;
                else if (timeout_hit) state_nx = ST_FAULT;
            end
            ST_VALID: begin
                if (advance) state_nx = misaligned ? ST_FAULT : ST_FETCH;
            end
            ST_FAULT: state_nx = ST_FAULT;
            default:  state_nx = ST_FAULT;
        endcase
    end

    always_comb begin
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        fault      = 1'b0;
        case (state)
            ST_FETCH: imem_req   = 1'b1;
            ST_VALID: inst_valid = 1'b1;
            ST_FAULT: fault      = 1'b1;
            default:  fault      = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_sc_fetch_unit.sv
// tb/tb_sc_fetch_unit.sv - self-checking bench for sc_fetch_unit
module tb_sc_fetch_unit;

    localparam int TIMEOUT = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = '0, rpc = '0, jpc = '0;
    logic        advance = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] inst, pc, pc4;
    logic        inst_valid, fault;
    logic [1:0]  fault_code;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    sc_fetch_unit #(.RESET_PC(32'h0), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .pcsource(pcsource), .bpc(bpc), .rpc(rpc),
        .jpc(jpc), .advance(advance), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .pc(pc),
        .pc4(pc4), .inst_valid(inst_valid), .fault(fault), .fault_code(fault_code)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 waiting for memory, 1 holding an instruction, 2 faulted.
    int          m_mode;
    logic [31:0] m_pc, m_inst;
    logic [1:0]  m_code;
    int          m_unanswered;

    always @(posedge clock) begin
        logic [31:0] target;
        if (reset) begin
            m_mode = 0; m_pc = 32'h0; m_inst = 32'h0; m_code = 2'b00; m_unanswered = 0;
        end else if (m_mode == 0) begin
            if (imem_ack) begin
                m_inst = imem_rdata; m_mode = 1; m_unanswered = 0;
            end else begin
                m_unanswered = m_unanswered + 1;
                if (m_unanswered >= TIMEOUT) begin m_mode = 2; m_code = 2'b10; end
            end
        end else if (m_mode == 1 && advance) begin
            case (pcsource)
                2'b00:   target = m_pc + 32'd4;
                2'b01:   target = bpc;
                2'b10:   target = rpc;
                default: target = jpc;
            endcase
            if (target % 4 != 0) begin m_mode = 2; m_code = 2'b01; end
            else begin m_pc = target; m_mode = 0; m_unanswered = 0; end
        end
    end

    always @(negedge clock) begin
        if (check_en) begin
            chk("imem_req",   32'(imem_req),   32'(m_mode == 0));
            chk("imem_addr",  imem_addr,       m_pc);
            chk("pc",         pc,              m_pc);
            chk("pc4",        pc4,             m_pc + 32'd4);
            chk("inst",       inst,            m_inst);
            chk("inst_valid", 32'(inst_valid), 32'(m_mode == 1));
            chk("fault",      32'(fault),      32'(m_mode == 2));
            chk("fault_code", 32'(fault_code), 32'(m_code));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Answer the current request after 'delay' idle cycles; advance is
    // optionally pulsed during the wait to show it is ignored in fetch.
    task automatic fetch(input logic [31:0] data, input int delay, input bit adv_noise);
        logic [31:0] a0;
        a0 = imem_addr;
        for (int i = 0; i < delay; i++) begin
            advance = adv_noise;
            cyc(1);
            chk("addr_stable", imem_addr, a0);
        end
        advance = 1'b0;
        imem_ack = 1'b1; imem_rdata = data;
        cyc(1);
        imem_ack = 1'b0;
    endtask

    task automatic step_pc(input logic [1:0] ps);
        pcsource = ps; advance = 1'b1;
        cyc(1);
        advance = 1'b0; pcsource = 2'b00;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        @(posedge clock); #1;
        check_en = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("lit_reset_req", 32'(imem_req), 32'd1);
        chk("lit_reset_addr", imem_addr, 32'h0);
        chk("lit_reset_inst", inst, 32'h0);

        // zero-wait fetch then sequential advance
        fetch(32'h2008_0005, 0, 1'b0);
        chk("lit_valid", 32'(inst_valid), 32'd1);
        chk("lit_inst", inst, 32'h2008_0005);
        step_pc(2'b00);
        chk("lit_seq_addr", imem_addr, 32'h4);

        // walk to 0x10 then branch, jump, jr
        for (int i = 0; i < 3; i++) begin
            fetch(32'h1000 + 32'(i), 0, 1'b0);
            step_pc(2'b00);
        end
        chk("lit_pc10", pc, 32'h10);
        fetch(32'hA1, 0, 1'b0);
        bpc = 32'h40; step_pc(2'b01);
        chk("lit_br", imem_addr, 32'h40);
        fetch(32'hA2, 0, 1'b0);
        jpc = 32'h100; step_pc(2'b11);
        chk("lit_j", imem_addr, 32'h100);
        fetch(32'hA3, 0, 1'b0);
        rpc = 32'h20; step_pc(2'b10);
        chk("lit_jr", imem_addr, 32'h20);

        // delayed ack with advance noise, then timeout
        fetch(32'hB0B0_0001, 5, 1'b1);
        chk("lit_delay_nofault", 32'(fault), 32'd0);
        chk("lit_delay_inst", inst, 32'hB0B0_0001);
        step_pc(2'b00);
        n = 0;
        while (imem_req === 1'b1 && n < 40) begin
            n++;
            cyc(1);
        end
        chk("lit_timeout_cycles", 32'(n), 32'd16);
        chk("lit_timeout_fault", 32'(fault), 32'd1);
        chk("lit_timeout_code", 32'(fault_code), 32'h2);
        chk("lit_timeout_req", 32'(imem_req), 32'd0);
        step_pc(2'b00);
        imem_ack = 1'b1; cyc(2); imem_ack = 1'b0;
        chk("lit_fault_sticky", 32'(fault), 32'd1);

        // misaligned jr target
        do_reset;
        fetch(32'hC0DE_0001, 0, 1'b0);
        rpc = 32'h0000_0022; step_pc(2'b10);
        chk("lit_mis_fault", 32'(fault), 32'd1);
        chk("lit_mis_code", 32'(fault_code), 32'h1);
        chk("lit_mis_pc", pc, 32'h0);
        chk("lit_mis_valid", 32'(inst_valid), 32'd0);
        do_reset;
        chk("lit_clr_fault", 32'(fault), 32'd0);
        chk("lit_clr_req", 32'(imem_req), 32'd1);

        // reset in fetch with a simultaneous ack
        fetch(32'hAAAA_5555, 0, 1'b0);
        step_pc(2'b00);
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        cyc(1);
        reset = 1'b0; imem_ack = 1'b0;
        chk("lit_rst_ack_inst", inst, 32'h0);
        chk("lit_rst_ack_addr", imem_addr, 32'h0);
        chk("lit_rst_ack_valid", 32'(inst_valid), 32'd0);
        cyc(1);
        chk("lit_rst_ack_req", 32'(imem_req), 32'd1);

        // wrap from top of address space, with long hold and stray acks
        fetch(32'hD1, 0, 1'b0);
        rpc = 32'hFFFF_FFFC; step_pc(2'b10);
        chk("lit_wrap_pc4", pc4, 32'h0);
        fetch(32'hD2, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            imem_ack = i[0]; imem_rdata = 32'hDEAD_0000 + 32'(i);
            cyc(1);
        end
        imem_ack = 1'b0;
        chk("lit_hold_req", 32'(imem_req), 32'd0);
        chk("lit_hold_inst", inst, 32'hD2);
        step_pc(2'b00);
        chk("lit_wrap_addr", imem_addr, 32'h0);
        chk("lit_wrap_fault", 32'(fault), 32'd0);

        cyc(1);
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
